// File: rtl/bpred_btb.sv
// bpred_btb: direct-mapped BTB with 2-bit PHT and saturating perf counters.
// Define BPRED_GSHARE_EN to index the PHT with btb_idx ^ global history.
module bpred_btb #(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 10,
  parameter int GHR_W   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] f_pc,
  output logic        f_hit,
  output logic        f_pred_taken,
  output logic [63:0] f_pred_pc,
  input  logic        u_valid,
  input  logic [63:0] u_pc,
  input  logic        u_is_br,
  input  logic        u_is_jump,
  input  logic        u_taken,
  input  logic [63:0] u_target,
  input  logic        u_mispredict,
  output logic [31:0] perf_br,
  output logic [31:0] perf_mispred
);
  localparam int IDX_W = $clog2(ENTRIES);
  if (ENTRIES < 4 || (1 << IDX_W) != ENTRIES || GHR_W < 1 || GHR_W > IDX_W) begin : g_bad_cfg
    $error("bpred_btb: illegal parameters");
  end
  logic [ENTRIES-1:0]      valid_q, valid_d, jump_q, jump_d;
  logic [ENTRIES-1:0][1:0] ctr_q, ctr_d;
  logic [TAG_W-1:0]        tag_q [ENTRIES];
  logic [TAG_W-1:0]        tag_d [ENTRIES];
  logic [63:0]             tgt_q [ENTRIES];
  logic [63:0]             tgt_d [ENTRIES];
  logic [31:0]             perf_br_q, perf_br_d, perf_mp_q, perf_mp_d;
  logic [IDX_W-1:0]        f_idx, f_pidx, u_idx, u_pidx;
  logic [TAG_W-1:0]        f_tag, u_tag;
  logic                    u_fire, u_br, u_hit;
  logic [1:0]              u_ctr;
  logic                    unused;
  assign unused = ^{u_pc[63:IDX_W+TAG_W+2], u_pc[1:0]};
  assign f_idx  = f_pc[IDX_W+1:2];
  assign f_tag  = f_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx  = u_pc[IDX_W+1:2];
  assign u_tag  = u_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_fire = u_valid && (u_is_br || u_is_jump);
  assign u_br   = u_is_br && !u_is_jump;
  assign u_hit  = valid_q[u_idx] && tag_q[u_idx] == u_tag;
`ifdef BPRED_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;
  // Counter update and lookup both use the history as it stands this cycle.
  assign f_pidx = f_idx ^ IDX_W'(ghr_q);
  assign u_pidx = u_idx ^ IDX_W'(ghr_q);
  always_comb ghr_d = (u_fire && u_br) ? GHR_W'({ghr_q, u_taken}) : ghr_q;
  always_ff @(posedge clk) ghr_q <= reset ? '0 : ghr_d;
`else
  assign f_pidx = f_idx;
  assign u_pidx = u_idx;
`endif
  assign f_hit        = valid_q[f_idx] && tag_q[f_idx] == f_tag;
  assign f_pred_taken = f_hit && (jump_q[f_idx] || ctr_q[f_pidx][1]);
  assign f_pred_pc    = f_pred_taken ? tgt_q[f_idx] : f_pc + 64'd4;
  assign perf_br      = perf_br_q;
  assign perf_mispred = perf_mp_q;
  always_comb begin
    valid_d = valid_q;
    jump_d  = jump_q;
    ctr_d   = ctr_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    u_ctr   = ctr_q[u_pidx];
    if (u_fire && u_hit) begin
      if (u_taken) tgt_d[u_idx] = u_target;
      jump_d[u_idx] = u_is_jump;
      if (u_br) ctr_d[u_pidx] = u_taken ? u_ctr + {1'b0, ~&u_ctr} : u_ctr - {1'b0, |u_ctr};
    end else if (u_fire && u_taken) begin
      valid_d[u_idx] = 1'b1;
      tag_d[u_idx]   = u_tag;
      tgt_d[u_idx]   = u_target;
      jump_d[u_idx]  = u_is_jump;
      ctr_d[u_pidx]  = 2'b10;
    end
    perf_br_d = perf_br_q + 32'(u_valid && u_is_br && ~&perf_br_q);
    perf_mp_d = perf_mp_q + 32'(u_valid && u_mispredict && ~&perf_mp_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      ctr_q     <= {ENTRIES{2'b01}};
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      valid_q   <= valid_d;
      ctr_q     <= ctr_d;
      perf_br_q <= perf_br_d;
      perf_mp_q <= perf_mp_d;
    end
  end
  // Payload needs no reset: it is only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    jump_q <= jump_d;
    tag_q  <= tag_d;
    tgt_q  <= tgt_d;
  end
endmodule
